// File: rtl/light_dance_pkg.sv
// Shared encodings for the light dance controller: FSM states, pattern modes and
// ping-pong direction.
package light_dance_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      MODE_ROL   = 2'b00,
      MODE_ROR   = 2'b01,
      MODE_PONG  = 2'b10,
      MODE_BLINK = 2'b11
   } mode_e;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

endpackage

// File: rtl/light_dance_ctrl_tick_gen.sv
// Prescaler for the light dance controller: counts 0..DIV-1 while enabled and
// flags the cycle whose closing edge should advance the pattern.
module tick_gen #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic arst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Clear has priority so a stop on a would-be tick cycle suppresses the update.
   assign tick = enable && !clear && (cnt_q == CntLast);

endmodule

// File: rtl/light_dance_ctrl.sv
// LED dance sequencer: rotate-left/right, ping-pong or blink over WIDTH cells,
// advancing once every DIV cycles. Ping-pong needs LIGHT_DANCE_PINGPONG_EN.
module light_dance_ctrl
   import light_dance_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = 4
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             start,
   input  logic             stop,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] leds,
   output logic             busy,
   output logic             step
);

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [WIDTH-1:0] leds_q, leds_d;
   logic             step_q, step_d;
   logic             tick;
   logic             go, halt;
   logic [WIDTH-1:0] rol, ror;

`ifdef LIGHT_DANCE_PINGPONG_EN
   dir_e             dir_q, dir_d;
`endif

   assign go   = (state_q == ST_IDLE) && start && !stop;
   assign halt = (state_q == ST_RUN) && stop;

   tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk    (clk),
      .arst   (arst),
      .clear  ((state_q == ST_IDLE) || stop),
      .enable (state_q == ST_RUN),
      .tick   (tick)
   );

   // State register
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; stop always wins over start
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start && !stop) state_d = ST_RUN;
         ST_RUN:  if (stop)           state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs; busy is decoded from the state register only
   always_comb begin
      busy = (state_q == ST_RUN);
      leds = leds_q;
      step = step_q;
   end

   assign rol = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
   assign ror = {leds_q[0], leds_q[WIDTH-1:1]};

   always_comb begin
      leds_d = leds_q;
      mode_d = mode_q;
      step_d = 1'b0;
`ifdef LIGHT_DANCE_PINGPONG_EN
      dir_d  = dir_q;
`endif
      if (go) begin
         leds_d = WIDTH'(1);
         mode_d = mode_e'(mode);
`ifdef LIGHT_DANCE_PINGPONG_EN
         dir_d  = DIR_LEFT;
`endif
      end else if (halt) begin
         leds_d = '0;
      end else if (tick) begin
         step_d = 1'b1;
         unique case (mode_q)
            MODE_ROL:   leds_d = rol;
            MODE_ROR:   leds_d = ror;
            MODE_BLINK: leds_d = ~leds_q;
            MODE_PONG: begin
`ifdef LIGHT_DANCE_PINGPONG_EN
               // Turn around on the end cell so neither end value repeats.
               if (dir_q == DIR_LEFT) begin
                  if (leds_q[WIDTH-1]) begin
                     dir_d  = DIR_RIGHT;
                     leds_d = leds_q >> 1;
                  end else begin
                     leds_d = leds_q << 1;
                  end
               end else begin
                  if (leds_q[0]) begin
                     dir_d  = DIR_LEFT;
                     leds_d = leds_q << 1;
                  end else begin
                     leds_d = leds_q >> 1;
                  end
               end
`else
               leds_d = rol;
`endif
            end
            default: leds_d = rol;
         endcase
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         leds_q <= '0;
         mode_q <= MODE_ROL;
         step_q <= 1'b0;
      end else begin
         leds_q <= leds_d;
         mode_q <= mode_d;
         step_q <= step_d;
      end
   end

`ifdef LIGHT_DANCE_PINGPONG_EN
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         dir_q <= DIR_LEFT;
      end else begin
         dir_q <= dir_d;
      end
   end
`endif

endmodule

// File: doc/light_dance_ctrl.md
LIGHT_DANCE_CTRL -- requirements
Module: light_dance_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: number of LED flip-flop cells sequenced; legal range 2..32.
REQ-002 Parameter DIV, default 4: clock cycles per pattern step; legal range 1..65535.
REQ-003 clk  input  1  clock; all state updates on the posedge.
REQ-004 arst  input  1  asynchronous reset, active-high.
REQ-005 start  input  1  level, sampled each posedge; begins a dance when idle.
REQ-006 stop  input  1  level, sampled each posedge; ends a dance.
REQ-007 mode  input  2  pattern select: 00 rotate-left, 01 rotate-right, 10 ping-pong, 11 blink.
REQ-008 leds  output  WIDTH  registered LED pattern.
REQ-009 busy  output  1  high while in RUN.
REQ-010 step  output  1  one-cycle pulse on every pattern update.

Function
REQ-011 The FSM SHALL have two states, IDLE and RUN.
REQ-012 IDLE with start=1 and stop=0 -> RUN on the next edge; on that edge: leds=1 (LSB only), prescaler=0, mode latched, ping-pong direction=left.
REQ-013 mode SHALL be sampled only on the IDLE->RUN edge; later mode changes are ignored until the next start.
REQ-014 In RUN the prescaler SHALL count 0..DIV-1 and wrap; a tick occurs on the edge where it equals DIV-1 (DIV=1: tick every cycle).
REQ-015 First update DIV cycles after entering RUN; step SHALL be high for exactly the cycle following each update edge, aligned with the new leds value.
REQ-016 Rotate-left on tick: leds = {leds[WIDTH-2:0], leds[WIDTH-1]}; rotate-right mirrors it; wrap-around is bit-exact.
REQ-017 Ping-pong on tick: direction left with MSB set -> direction=right and shift right by 1; direction right with LSB set -> direction=left and shift left by 1; otherwise shift by 1 in the current direction, zero-filled.
REQ-018 Blink on tick: leds = ~leds.
REQ-019 stop=1 in RUN -> IDLE on the next edge; leds=0, prescaler=0, step=0.
REQ-020 start and stop high in the same cycle: stop wins; IDLE stays IDLE, RUN goes to IDLE.
REQ-021 start in RUN SHALL be ignored; it does not restart.
REQ-022 busy SHALL equal (state==RUN), registered, with no combinational path from inputs.

Reset
REQ-023 arst high SHALL immediately force state=IDLE, leds=0, busy=0, step=0, prescaler=0, direction=left, latched mode=00, independent of clk.
REQ-024 Reset mid-dance SHALL discard all progress; operation resumes only on a new start after arst deasserts.

Configuration
REQ-025 Macro LIGHT_DANCE_PINGPONG_EN defined: mode 10 is ping-pong per REQ-017, and the direction register exists.
REQ-026 Macro LIGHT_DANCE_PINGPONG_EN undefined: mode 10 behaves identically to rotate-left (00), and no direction register is synthesized.

Structure
REQ-027 Package light_dance_pkg SHALL hold the mode encodings (MODE_ROL, MODE_ROR, MODE_PONG, MODE_BLINK) and the state encodings (ST_IDLE, ST_RUN).
REQ-028 The prescaler SHALL be a sub-module tick_gen (inputs clk, arst, clear, enable; output tick; parameter DIV).

Verification (WIDTH=8, DIV=4)
REQ-029 Reset: arst pulsed mid-RUN with leds=0x10 -> leds=0x00, busy=0, step=0 before the next clk edge.
REQ-030 Rotate-left: start with mode=00 -> leds=0x01, then 0x02, 0x04 ... 0x80, 0x01 at 4-cycle spacing; one step pulse per update; toggling mode mid-run has no effect.
REQ-031 Ping-pong (macro defined): mode=10 -> 0x01 ... 0x80, 0x40 ... 0x01, 0x02; no value is repeated at either end.
REQ-032 Blink: mode=11 -> 0x01, 0xFE, 0x01, 0xFE at 4-cycle spacing.
REQ-033 Handshake edges: start+stop together in IDLE -> busy stays 0; stop in RUN -> leds=0x00, busy=0 next cycle; start held in RUN -> no restart.
REQ-034 Macro undefined: mode=10 -> 0x80 followed by 0x01, same as rotate-left.
